if_stage: RTL and testbench

// Instruction-fetch stage: the consumer of the EXE branch outputs (br_select, br_pc) and the producer of the
// pc_out value EXE uses as its branch base. Owns the PC, drives a request/ready instruction-memory port,
// and contains the IF/ID output register. Handles hazard freeze and branch flush, including redirects

---
 rtl/if_stage.sv | 102 ++++++++++
 tb/tb_if_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a request/ready instruction-memory
// port and holds the IF/ID register, with hazard freeze and branch flush handling.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        br_select,
  input  logic [31:0] br_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        valid,
  output logic        flush_out
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic [31:0] pc_inc;
  logic [31:0] br_target;

  assign pc_inc    = pc + 32'd4;
  assign br_target = br_pc & 32'hFFFF_FFFC;
  assign imem_req  = (state != HOLD);
  assign imem_addr = pc;
  assign flush_out = br_select;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect    <= '0;
      buf_instr   <= '0;
      buf_pc      <= '0;
      pc_out      <= '0;
      instruction <= '0;
      valid       <= 1'b0;
    end else begin
      // A taken branch always bubbles IF/ID, independent of state and freeze.
      if (br_select) begin
        valid       <= 1'b0;
        instruction <= '0;
      end
      unique case (state)
        FETCH: begin
          if (br_select) begin
            if (imem_ready) begin
              pc <= br_target;
            end else begin
              redirect <= br_target;
              state    <= DISCARD;
            end
          end else if (imem_ready) begin
            pc <= pc_inc;
            if (freeze) begin
              buf_instr <= imem_rdata;
              buf_pc    <= pc_inc;
              state     <= HOLD;
            end else begin
              instruction <= imem_rdata;
              pc_out      <= pc_inc;
              valid       <= 1'b1;
            end
          end else if (!freeze) begin
            valid <= 1'b0;
          end
        end
        HOLD: begin
          if (br_select) begin
            pc    <= br_target;
            state <= FETCH;
          end else if (!freeze) begin
            instruction <= buf_instr;
            pc_out      <= buf_pc;
            valid       <= 1'b1;
            state       <= FETCH;
          end
        end
        DISCARD: begin
          // The stale request must still complete; the newest target wins.
          if (imem_ready) begin
            pc    <= br_select ? br_target : redirect;
            state <= FETCH;
          end else if (br_select) begin
            redirect <= br_target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against a transaction-level fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        br_select;
  logic [31:0] br_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid;
  logic        flush_out;

  // Second instance: wrap-around reset address, always-ready memory.
  logic        tie0 = 1'b0;
  logic        tie1 = 1'b1;
  logic [31:0] tie32 = 32'h0;
  logic        req2;
  logic [31:0] addr2;
  logic [31:0] rdata2;
  logic [31:0] pc_out2;
  logic [31:0] instr2;
  logic        valid2;
  logic        flush2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_tgt, m_pc_out, m_instr, m_bpc, m_binstr;
  logic        m_valid, m_drop, m_hold;

  always #5 clk = ~clk;

  assign rdata2 = addr2 ^ 32'hA5A5_0000;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .br_select(br_select), .br_pc(br_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc_out(pc_out), .instruction(instruction),
    .valid(valid), .flush_out(flush_out)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .freeze(tie0), .br_select(tie0), .br_pc(tie32),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(tie1),
    .imem_rdata(rdata2), .pc_out(pc_out2), .instruction(instr2),
    .valid(valid2), .flush_out(flush2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_tgt = 32'h0; m_pc_out = 32'h0; m_instr = 32'h0;
    m_bpc = 32'h0; m_binstr = 32'h0;
    m_valid = 1'b0; m_drop = 1'b0; m_hold = 1'b0;
  endtask

  // One clock of the fetch contract: a doomed request, a one-word buffer, or normal flow.
  task automatic model_step(input logic fr, input logic br, input logic [31:0] bp,
                            input logic rdy, input logic [31:0] rd);
    if (br) begin
      m_valid = 1'b0;
      m_instr = 32'h0;
      if (m_hold) begin
        m_hold = 1'b0;
        m_pc   = bp;
      end else if (rdy) begin
        m_pc   = bp;
        m_drop = 1'b0;
      end else begin
        m_drop = 1'b1;
        m_tgt  = bp;
      end
    end else if (m_hold) begin
      if (!fr) begin
        m_hold = 1'b0; m_valid = 1'b1; m_instr = m_binstr; m_pc_out = m_bpc;
      end
    end else if (m_drop) begin
      if (rdy) begin
        m_pc = m_tgt; m_drop = 1'b0;
      end
    end else if (rdy) begin
      if (fr) begin
        m_hold = 1'b1; m_bpc = m_pc + 32'd4; m_binstr = rd;
      end else begin
        m_valid = 1'b1; m_instr = rd; m_pc_out = m_pc + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end else if (!fr) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cyc(input logic fr, input logic br, input logic [31:0] bp, input logic rdy);
    @(negedge clk);
    check("imem_req", 32'(imem_req), 32'(!m_hold));
    if (!m_hold) check("imem_addr", imem_addr, m_pc);
    check("pc_out", pc_out, m_pc_out);
    check("instruction", instruction, m_instr);
    check("valid", 32'(valid), 32'(m_valid));
    if (valid === 1'b1) check("instr_matches_pc", instruction, (pc_out - 32'd4) ^ 32'hA5A5_0000);
    freeze     = fr;
    br_select  = br;
    br_pc      = bp;
    imem_ready = rdy & imem_req;
    imem_rdata = imem_addr ^ 32'hA5A5_0000;
    #1;
    check("flush_out", 32'(flush_out), 32'(br));
    model_step(fr, br, bp & 32'hFFFF_FFFC, imem_ready, imem_rdata);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    imem_ready = 1'b0; freeze = 1'b0; br_select = 1'b0; br_pc = 32'h0;
    #1;
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; br_select = 1'b0; br_pc = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    model_reset();
    do_reset();

    // Zero-wait streaming; the wrap-around instance is checked alongside.
    cyc(0, 0, 0, 1);
    check("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    check("wrap_first_req", 32'(req2), 32'h1);
    cyc(0, 0, 0, 1);
    check("wrap_second_addr", addr2, 32'h0);
    check("wrap_pc_out0", pc_out2, 32'h0);
    check("wrap_instr0", instr2, 32'hFFFF_FFFC ^ 32'hA5A5_0000);
    cyc(0, 0, 0, 1);
    check("wrap_pc_out1", pc_out2, 32'h4);
    check("wrap_valid", 32'(valid2), 32'h1);
    check("wrap_flush", 32'(flush2), 32'h0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

    // Freeze for three cycles while streaming.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    // Branch while a slow request to 0x8 is outstanding.
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 32'h100, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    @(posedge clk); #1;
    check("redirect_addr", imem_addr, 32'h100);
    check("redirect_valid", 32'(valid), 32'h0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Branch and freeze in the same cycle.
    cyc(1, 1, 32'h43, 1);
    @(posedge clk); #1;
    check("brfrz_valid", 32'(valid), 32'h0);
    check("brfrz_addr", imem_addr, 32'h40);
    cyc(0, 0, 0, 1);

    // Mid-request reset with ready low.
    cyc(0, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 499) do_reset();
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom,
          ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
